// File: rtl/breakout_ball_engine_pkg.sv
// Shared geometry defaults, direction encodings, FSM state type and the
// brick-cell addressing helper for the breakout ball engine.
package breakout_pkg;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int POS_W     = 10;
  localparam int COLS      = 20;
  localparam int ROWS      = 24;
  localparam int HP_W      = 3;
  localparam int BRICK_W   = 32;
  localparam int BRICK_H   = 8;
  localparam int BALL_SIZE = 8;
  localparam int VEL_W     = 4;
  localparam int PADDLE_W  = 96;
  localparam int PADDLE_Y  = 448;
  localparam int X0        = 320;
  localparam int Y0        = 240;
  localparam int VX0       = 4;
  localparam int VY0       = 3;

  // Direction bits: x grows to the right, y grows downwards.
  localparam logic DX_RIGHT = 1'b1;
  localparam logic DX_LEFT  = 1'b0;
  localparam logic DY_DOWN  = 1'b1;
  localparam logic DY_UP    = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MOVE   = 3'd1,
    ST_WALL   = 3'd2,
    ST_BRICK  = 3'd3,
    ST_PADDLE = 3'd4,
    ST_COMMIT = 3'd5
  } state_t;

  // Bit offset of brick cell (col,row) inside the packed HP field.
  function automatic int cell_offset(input int col, input int row,
                                     input int cols, input int hp_w);
    return hp_w * (col + cols * row);
  endfunction

endpackage

// File: rtl/breakout_ball_engine_if.sv
// Control/status bundle between the game top level and the ball engine.
// The game side (master) drives strobes, level image and paddle position;
// the engine (slave) returns ball position, brick field and event pulses.
interface breakout_ball_engine_if #(
  parameter int POS_W = breakout_pkg::POS_W,
  parameter int COLS  = breakout_pkg::COLS,
  parameter int ROWS  = breakout_pkg::ROWS,
  parameter int HP_W  = breakout_pkg::HP_W
);
  logic                       tick;
  logic                       load;
  logic [COLS*ROWS*HP_W-1:0]  level_data;
  logic [POS_W-1:0]           paddle_x;
  logic [POS_W-1:0]           ball_x;
  logic [POS_W-1:0]           ball_y;
  logic [COLS*ROWS*HP_W-1:0]  bricks;
  logic                       busy;
  logic                       done;
  logic                       brick_hit;
  logic [4:0]                 hit_col;
  logic [4:0]                 hit_row;
  logic                       ball_lost;
  logic                       all_cleared;

  modport master (
    output tick, load, level_data, paddle_x,
    input  ball_x, ball_y, bricks, busy, done, brick_hit,
           hit_col, hit_row, ball_lost, all_cleared
  );

  modport slave (
    input  tick, load, level_data, paddle_x,
    output ball_x, ball_y, bricks, busy, done, brick_hit,
           hit_col, hit_row, ball_lost, all_cleared
  );
endinterface

// File: rtl/breakout_ball_engine_brick_probe.sv
// Combinational brick lookup: maps the ball centre to a brick cell and
// returns that cell's hit points (zero when the centre is outside the field).
module brick_probe #(
  parameter int POS_W   = breakout_pkg::POS_W,
  parameter int COLS    = breakout_pkg::COLS,
  parameter int ROWS    = breakout_pkg::ROWS,
  parameter int HP_W    = breakout_pkg::HP_W,
  parameter int BRICK_W = breakout_pkg::BRICK_W,
  parameter int BRICK_H = breakout_pkg::BRICK_H
) (
  input  logic [POS_W:0]               cx,
  input  logic [POS_W:0]               cy,
  input  logic [COLS*ROWS*HP_W-1:0]    bricks,
  output logic [4:0]                   col,
  output logic [4:0]                   row,
  output logic                         in_field,
  output logic [HP_W-1:0]              hp
);
  import breakout_pkg::*;

  localparam int FB    = COLS * ROWS * HP_W;
  localparam int OFF_W = $clog2(FB);
  localparam int CSH   = $clog2(BRICK_W);
  localparam int RSH   = $clog2(BRICK_H);

  logic [POS_W:0]   col_full;
  logic [POS_W:0]   row_full;
  logic [OFF_W-1:0] off;

  // Cell index from the centre point, range check, then HP read-out.
  always_comb begin
    col_full = cx >> CSH;
    row_full = cy >> RSH;
    in_field = (col_full < (POS_W+1)'(COLS)) && (row_full < (POS_W+1)'(ROWS));
    col      = col_full[4:0];
    row      = row_full[4:0];
    if (in_field) begin
      off = OFF_W'(cell_offset(int'(col), int'(row), COLS, HP_W));
      hp  = bricks[off +: HP_W];
    end else begin
      off = {OFF_W{1'b0}};
      hp  = {HP_W{1'b0}};
    end
  end
endmodule

// File: rtl/breakout_ball_engine.sv
// Ball-physics and brick-field engine. Each tick runs a five-stage step
// (move, wall, brick, paddle, commit); the visible ball state and brick
// field change only at commit, and a level load aborts any step in flight.
module breakout_ball_engine #(
  parameter int SCREEN_W  = breakout_pkg::SCREEN_W,
  parameter int SCREEN_H  = breakout_pkg::SCREEN_H,
  parameter int POS_W     = breakout_pkg::POS_W,
  parameter int COLS      = breakout_pkg::COLS,
  parameter int ROWS      = breakout_pkg::ROWS,
  parameter int HP_W      = breakout_pkg::HP_W,
  parameter int BRICK_W   = breakout_pkg::BRICK_W,
  parameter int BRICK_H   = breakout_pkg::BRICK_H,
  parameter int BALL_SIZE = breakout_pkg::BALL_SIZE,
  parameter int VEL_W     = breakout_pkg::VEL_W,
  parameter int PADDLE_W  = breakout_pkg::PADDLE_W,
  parameter int PADDLE_Y  = breakout_pkg::PADDLE_Y,
  parameter int X0        = breakout_pkg::X0,
  parameter int Y0        = breakout_pkg::Y0,
  parameter int VX0       = breakout_pkg::VX0,
  parameter int VY0       = breakout_pkg::VY0
) (
  input logic                    clk,
  input logic                    rst,
  breakout_ball_engine_if.slave  bus
);
  import breakout_pkg::*;

  localparam int FB    = COLS * ROWS * HP_W;
  localparam int OFF_W = $clog2(FB);
  localparam int PW    = POS_W + 2;

  // Speeds are fixed magnitudes; direction lives in dx/dy.
  localparam logic [VEL_W-1:0]      VX_MAG = VEL_W'(VX0);
  localparam logic [VEL_W-1:0]      VY_MAG = VEL_W'(VY0);
  localparam logic signed [POS_W:0] VX_S   = $signed((POS_W+1)'(VX_MAG));
  localparam logic signed [POS_W:0] VY_S   = $signed((POS_W+1)'(VY_MAG));
  localparam logic signed [POS_W:0] XMAX_S = (POS_W+1)'(SCREEN_W - BALL_SIZE);
  localparam logic signed [POS_W:0] YMAX_S = (POS_W+1)'(SCREEN_H - BALL_SIZE);
  localparam logic signed [POS_W:0] PTOP_S = (POS_W+1)'(PADDLE_Y - BALL_SIZE);
  localparam logic [POS_W-1:0]      X0_U   = POS_W'(X0);
  localparam logic [POS_W-1:0]      Y0_U   = POS_W'(Y0);
  localparam logic [POS_W:0]        HALF_U = (POS_W+1)'(BALL_SIZE / 2);

  state_t state, state_next;

  // Committed ball state.
  logic [POS_W-1:0] x, y;
  logic             dx, dy;
  // Work copy of the step in progress.
  logic signed [POS_W:0] nx, ny;
  logic                  ndx, ndy, lost, hit;
  logic [4:0]            pend_col, pend_row;
  logic [OFF_W-1:0]      hit_off;
  logic [HP_W-1:0]       hp_new;
  // Visible outputs.
  logic [FB-1:0]    bricks;
  logic             busy, done, brick_hit, ball_lost, all_cleared;
  logic [4:0]       hit_col, hit_row;

  logic [POS_W:0]   cx, cy;
  logic [4:0]       probe_col, probe_row;
  logic             probe_in;
  logic [HP_W-1:0]  probe_hp;
  logic [PW-1:0]    pcx, pleft, y_bot, ny_bot;
  logic             paddle_hit, paddle_dx;
  logic [FB-1:0]    field_next;

  assign cx = $unsigned(nx) + HALF_U;
  assign cy = $unsigned(ny) + HALF_U;

  brick_probe #(
    .POS_W(POS_W), .COLS(COLS), .ROWS(ROWS), .HP_W(HP_W),
    .BRICK_W(BRICK_W), .BRICK_H(BRICK_H)
  ) u_probe (
    .cx(cx), .cy(cy), .bricks(bricks),
    .col(probe_col), .row(probe_row), .in_field(probe_in), .hp(probe_hp)
  );

  // Paddle contact test and the steering zone (left/middle/right third).
  always_comb begin
    pcx    = PW'(cx);
    pleft  = PW'(bus.paddle_x);
    y_bot  = PW'(y) + PW'(BALL_SIZE);
    ny_bot = PW'($unsigned(ny)) + PW'(BALL_SIZE);
    paddle_hit = !lost && (ndy == DY_DOWN) &&
                 (y_bot <= PW'(PADDLE_Y)) && (ny_bot >= PW'(PADDLE_Y)) &&
                 (pcx >= pleft) && (pcx < pleft + PW'(PADDLE_W));
    if (pcx < pleft + PW'(PADDLE_W / 3)) begin
      paddle_dx = DX_LEFT;
    end else if (pcx >= pleft + PW'((2 * PADDLE_W) / 3)) begin
      paddle_dx = DX_RIGHT;
    end else begin
      paddle_dx = ndx;
    end
  end

  // Brick field as it will look after this step commits.
  always_comb begin
    field_next = bricks;
    if (hit) begin
      field_next[hit_off +: HP_W] = hp_new;
    end else begin
      field_next = bricks;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM sequencing: one cycle per stage, load always returns to idle.
  always_comb begin
    state_next = state;
    if (bus.load) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.tick) begin
            state_next = ST_MOVE;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_MOVE:   state_next = ST_WALL;
        ST_WALL:   state_next = ST_BRICK;
        ST_BRICK:  state_next = ST_PADDLE;
        ST_PADDLE: state_next = ST_COMMIT;
        ST_COMMIT: state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  // Step datapath: each FSM stage refines the work copy; commit publishes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= X0_U;  y <= Y0_U;  dx <= DX_RIGHT;  dy <= DY_UP;
      nx <= '0;  ny <= '0;  ndx <= DX_RIGHT;  ndy <= DY_UP;
      lost <= 1'b0;  hit <= 1'b0;
      pend_col <= 5'd0;  pend_row <= 5'd0;
      hit_off <= {OFF_W{1'b0}};  hp_new <= {HP_W{1'b0}};
      bricks <= {FB{1'b0}};  all_cleared <= 1'b1;
      busy <= 1'b0;  done <= 1'b0;  brick_hit <= 1'b0;  ball_lost <= 1'b0;
      hit_col <= 5'd0;  hit_row <= 5'd0;
    end else if (bus.load) begin
      bricks      <= bus.level_data;
      all_cleared <= ~|bus.level_data;
      x <= X0_U;  y <= Y0_U;  dx <= DX_RIGHT;  dy <= DY_UP;
      busy <= 1'b0;  done <= 1'b0;  brick_hit <= 1'b0;  ball_lost <= 1'b0;
    end else begin
      busy      <= (state_next != ST_IDLE);
      done      <= 1'b0;
      brick_hit <= 1'b0;
      ball_lost <= 1'b0;
      case (state)
        ST_MOVE: begin
          nx   <= (dx == DX_RIGHT) ? ($signed({1'b0, x}) + VX_S) : ($signed({1'b0, x}) - VX_S);
          ny   <= (dy == DY_DOWN)  ? ($signed({1'b0, y}) + VY_S) : ($signed({1'b0, y}) - VY_S);
          ndx  <= dx;
          ndy  <= dy;
          lost <= 1'b0;
          hit  <= 1'b0;
        end
        ST_WALL: begin
          if (ny > YMAX_S) begin
            // Fell past the bottom: respawn, keep the pre-step x direction.
            nx   <= $signed({1'b0, X0_U});
            ny   <= $signed({1'b0, Y0_U});
            ndx  <= dx;
            ndy  <= DY_UP;
            lost <= 1'b1;
          end else begin
            if (nx[POS_W]) begin
              nx  <= '0;
              ndx <= DX_RIGHT;
            end else if (nx > XMAX_S) begin
              nx  <= XMAX_S;
              ndx <= DX_LEFT;
            end else begin
              ndx <= ndx;
            end
            if (ny[POS_W]) begin
              ny  <= '0;
              ndy <= DY_DOWN;
            end else begin
              ndy <= ndy;
            end
          end
        end
        ST_BRICK: begin
          if (!lost && probe_in && (probe_hp != {HP_W{1'b0}})) begin
            hit      <= 1'b1;
            hp_new   <= probe_hp - HP_W'(1'b1);
            hit_off  <= OFF_W'(cell_offset(int'(probe_col), int'(probe_row), COLS, HP_W));
            pend_col <= probe_col;
            pend_row <= probe_row;
            ndy      <= ~ndy;
            ny       <= $signed({1'b0, y});
          end else begin
            hit <= 1'b0;
          end
        end
        ST_PADDLE: begin
          if (paddle_hit) begin
            ny  <= PTOP_S;
            ndy <= DY_UP;
            ndx <= paddle_dx;
          end else begin
            ndy <= ndy;
          end
        end
        ST_COMMIT: begin
          x           <= nx[POS_W-1:0];
          y           <= ny[POS_W-1:0];
          dx          <= ndx;
          dy          <= ndy;
          bricks      <= field_next;
          all_cleared <= ~|field_next;
          done        <= 1'b1;
          brick_hit   <= hit;
          ball_lost   <= lost;
          if (hit) begin
            hit_col <= pend_col;
            hit_row <= pend_row;
          end else begin
            hit_col <= hit_col;
            hit_row <= hit_row;
          end
        end
        default: begin
          hit <= hit;
        end
      endcase
    end
  end

  assign bus.ball_x      = x;
  assign bus.ball_y      = y;
  assign bus.bricks      = bricks;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.brick_hit   = brick_hit;
  assign bus.hit_col     = hit_col;
  assign bus.hit_row     = hit_row;
  assign bus.ball_lost   = ball_lost;
  assign bus.all_cleared = all_cleared;

endmodule
